object_access_scheduler: RTL and testbench

//  Sequences and shares the object storage BRAM bank (4 read lanes, 1 write port).
//  - Runs read sweeps over all stored objects, 4 per beat, and forwards tagged results to the physics/render consumer.
//  - Arbitrates the single write port between the physics writeback and the AR/camera ingest requesters.
//  - Sits between those clients and object_storage.

---
 rtl/object_access_scheduler.sv | 215 +++++++++++++++++++++
 tb/tb_object_access_scheduler.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/object_access_scheduler.sv
// Object storage front end: 4-lane read sweeps with tagged results, and round-robin sharing of the write port.
// Optional build macro SWEEP_WRITE_LOCK_EN holds off all write grants while a sweep is running.
module object_access_scheduler #(
  parameter int OBJ_WIDTH  = 115,
  parameter int OBJ_COUNT  = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  sweep_start_in,
  output logic                  sweep_busy_out,
  output logic                  sweep_done_out,
  output logic                  obj_valid_out,
  output logic [ADDR_WIDTH-1:0] obj_base_addr_out,
  output logic [3:0]            obj_lane_mask_out,
  output logic [OBJ_WIDTH-1:0]  obj_data_out [3:0],
  input  logic                  phys_wr_valid_in,
  output logic                  phys_wr_ready_out,
  input  logic [ADDR_WIDTH-1:0] phys_wr_addr_in,
  input  logic [OBJ_WIDTH-1:0]  phys_wr_obj_in,
  input  logic                  ar_wr_valid_in,
  output logic                  ar_wr_ready_out,
  input  logic [ADDR_WIDTH-1:0] ar_wr_addr_in,
  input  logic [OBJ_WIDTH-1:0]  ar_wr_obj_in,
  output logic                  st_read_valid_out,
  output logic [ADDR_WIDTH-1:0] st_read_addrs_out [3:0],
  input  logic [OBJ_WIDTH-1:0]  st_read_objects_in [3:0],
  input  logic                  st_read_valid_in,
  output logic                  st_write_valid_out,
  output logic [ADDR_WIDTH-1:0] st_write_addr_out,
  output logic [OBJ_WIDTH-1:0]  st_write_object_out
);
  localparam int NUM_GROUPS = (OBJ_COUNT + 3) / 4;
  localparam logic [ADDR_WIDTH-1:0] LAST_BASE   = ADDR_WIDTH'((NUM_GROUPS - 1) * 4);
  localparam logic [ADDR_WIDTH+1:0] OBJ_COUNT_W = (ADDR_WIDTH + 2)'(OBJ_COUNT);

  // S_IDLE: wait for start | S_ISSUE: one read group per cycle | S_DRAIN: wait for last beat
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t                state_q;
  logic                  busy_q;
  logic                  rd_valid_q;
  logic [ADDR_WIDTH-1:0] rd_addrs_q [3:0];
  logic [ADDR_WIDTH-1:0] rd_base_q;
  logic [3:0]            rd_mask_q;
  logic                  rd_last_q;

  logic [RD_LATENCY-1:0] pipe_vld_q;
  logic [RD_LATENCY-1:0] pipe_last_q;
  logic [ADDR_WIDTH-1:0] pipe_base_q [RD_LATENCY];
  logic [3:0]            pipe_mask_q [RD_LATENCY];

  logic                  obj_valid_q;
  logic                  done_q;
  logic [ADDR_WIDTH-1:0] obj_base_q;
  logic [3:0]            obj_mask_q;
  logic [OBJ_WIDTH-1:0]  obj_data_q [3:0];

  logic                  last_ar_q;
  logic                  wr_valid_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [OBJ_WIDTH-1:0]  wr_obj_q;

  logic [ADDR_WIDTH-1:0] base_d;
  logic [ADDR_WIDTH+1:0] lane_sum [3:0];
  logic [3:0]            mask_d;
  logic [ADDR_WIDTH-1:0] addrs_d [3:0];
  logic                  beat_fire;
  logic                  wr_open;
  logic                  phys_grant;
  logic                  ar_grant;

  always_comb begin
    base_d = (state_q == S_ISSUE) ? rd_base_q + ADDR_WIDTH'(4) : '0;
    mask_d = '0;
    for (int i = 0; i < 4; i++) begin
      lane_sum[i] = {2'b00, base_d} + (ADDR_WIDTH + 2)'(i);
      mask_d[i]   = lane_sum[i] < OBJ_COUNT_W;
      addrs_d[i]  = mask_d[i] ? lane_sum[i][ADDR_WIDTH-1:0] : '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_base_q  <= '0;
      rd_mask_q  <= '0;
      rd_last_q  <= 1'b0;
      for (int i = 0; i < 4; i++) rd_addrs_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (sweep_start_in) begin
          state_q    <= S_ISSUE;
          busy_q     <= 1'b1;
          rd_valid_q <= 1'b1;
          rd_base_q  <= base_d;
          rd_mask_q  <= mask_d;
          rd_last_q  <= (base_d == LAST_BASE);
          rd_addrs_q <= addrs_d;
        end
        S_ISSUE: if (rd_last_q) begin
          state_q    <= S_DRAIN;
          rd_valid_q <= 1'b0;
          rd_mask_q  <= '0;
          rd_last_q  <= 1'b0;
          for (int i = 0; i < 4; i++) rd_addrs_q[i] <= '0;
        end else begin
          rd_base_q  <= base_d;
          rd_mask_q  <= mask_d;
          rd_last_q  <= (base_d == LAST_BASE);
          rd_addrs_q <= addrs_d;
        end
        S_DRAIN: if (done_q && pipe_vld_q == '0) begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Tag pipeline tracks storage latency; its valid bit lets stale storage beats be ignored after reset.
  assign beat_fire = st_read_valid_in & pipe_vld_q[RD_LATENCY-1];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_base_q[i] <= '0;
        pipe_mask_q[i] <= '0;
      end
      obj_valid_q <= 1'b0;
      done_q      <= 1'b0;
      obj_base_q  <= '0;
      obj_mask_q  <= '0;
      for (int i = 0; i < 4; i++) obj_data_q[i] <= '0;
    end else begin
      pipe_vld_q[0]  <= rd_valid_q;
      pipe_last_q[0] <= rd_valid_q & rd_last_q;
      pipe_base_q[0] <= rd_base_q;
      pipe_mask_q[0] <= rd_mask_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_last_q[i] <= pipe_last_q[i-1];
        pipe_base_q[i] <= pipe_base_q[i-1];
        pipe_mask_q[i] <= pipe_mask_q[i-1];
      end
      obj_valid_q <= beat_fire;
      done_q      <= beat_fire & pipe_last_q[RD_LATENCY-1];
      if (beat_fire) begin
        obj_base_q <= pipe_base_q[RD_LATENCY-1];
        obj_mask_q <= pipe_mask_q[RD_LATENCY-1];
        obj_data_q <= st_read_objects_in;
      end
    end
  end

`ifdef SWEEP_WRITE_LOCK_EN
  assign wr_open = rst_n_in & ~busy_q & ~((state_q == S_IDLE) & sweep_start_in);
`else
  assign wr_open = rst_n_in;
`endif

  always_comb begin
    phys_grant = 1'b0;
    ar_grant   = 1'b0;
    if (wr_open) begin
      if (phys_wr_valid_in && ar_wr_valid_in) begin
        phys_grant = last_ar_q;
        ar_grant   = ~last_ar_q;
      end else begin
        phys_grant = phys_wr_valid_in;
        ar_grant   = ar_wr_valid_in;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      last_ar_q  <= 1'b1;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_obj_q   <= '0;
    end else begin
      wr_valid_q <= phys_grant | ar_grant;
      if (phys_grant | ar_grant) last_ar_q <= ar_grant;
      if (phys_grant) begin
        wr_addr_q <= phys_wr_addr_in;
        wr_obj_q  <= phys_wr_obj_in;
      end else if (ar_grant) begin
        wr_addr_q <= ar_wr_addr_in;
        wr_obj_q  <= ar_wr_obj_in;
      end
    end
  end

  assign sweep_busy_out      = busy_q;
  assign sweep_done_out      = done_q;
  assign obj_valid_out       = obj_valid_q;
  assign obj_base_addr_out   = obj_base_q;
  assign obj_lane_mask_out   = obj_mask_q;
  assign obj_data_out        = obj_data_q;
  assign st_read_valid_out   = rd_valid_q;
  assign st_read_addrs_out   = rd_addrs_q;
  assign st_write_valid_out  = wr_valid_q;
  assign st_write_addr_out   = wr_addr_q;
  assign st_write_object_out = wr_obj_q;
  assign phys_wr_ready_out   = phys_grant;
  assign ar_wr_ready_out     = ar_grant;

endmodule

// File: tb/tb_object_access_scheduler.sv
// Directed bench for object_access_scheduler: two instances (4 and 6 objects) over a read-first storage model.
module tb_object_access_scheduler;
  localparam int OW = 115;
  localparam int AW = 8;

  logic clk;
  logic rst_n;
  logic mem_init;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [OW-1:0] obj_pat(input int k);
    return {15'(k + 7), 92'(0), 8'(k)};
  endfunction

  // instance a: OBJ_COUNT=4, read only
  logic          a_start, a_busy, a_done, a_ov, a_prdy, a_ardy, a_rv, a_wv;
  logic [AW-1:0] a_base, a_wa;
  logic [3:0]    a_mask;
  logic [OW-1:0] a_data [3:0];
  logic [AW-1:0] a_ra [3:0];
  logic [OW-1:0] a_d1 [3:0];
  logic [OW-1:0] a_d2 [3:0];
  logic          a_v1, a_v2;
  logic [OW-1:0] a_wo;

  // instance b: OBJ_COUNT=6, owns the write traffic
  logic          b_start, b_busy, b_done, b_ov, b_prdy, b_ardy, b_rv, b_wv;
  logic          b_pv, b_av;
  logic [AW-1:0] b_pa, b_aa, b_base, b_wa;
  logic [OW-1:0] b_po, b_ao, b_wo;
  logic [3:0]    b_mask;
  logic [OW-1:0] b_data [3:0];
  logic [AW-1:0] b_ra [3:0];
  logic [OW-1:0] b_d1 [3:0];
  logic [OW-1:0] b_d2 [3:0];
  logic          b_v1, b_v2;

  logic [OW-1:0] mem [256];

  object_access_scheduler #(.OBJ_WIDTH(OW), .OBJ_COUNT(4), .ADDR_WIDTH(AW), .RD_LATENCY(2)) u_dut_a (
    .clk_in(clk), .rst_n_in(rst_n), .sweep_start_in(a_start),
    .sweep_busy_out(a_busy), .sweep_done_out(a_done), .obj_valid_out(a_ov),
    .obj_base_addr_out(a_base), .obj_lane_mask_out(a_mask), .obj_data_out(a_data),
    .phys_wr_valid_in(1'b0), .phys_wr_ready_out(a_prdy), .phys_wr_addr_in(8'd0), .phys_wr_obj_in('0),
    .ar_wr_valid_in(1'b0), .ar_wr_ready_out(a_ardy), .ar_wr_addr_in(8'd0), .ar_wr_obj_in('0),
    .st_read_valid_out(a_rv), .st_read_addrs_out(a_ra), .st_read_objects_in(a_d2),
    .st_read_valid_in(a_v2), .st_write_valid_out(a_wv), .st_write_addr_out(a_wa),
    .st_write_object_out(a_wo)
  );

  object_access_scheduler #(.OBJ_WIDTH(OW), .OBJ_COUNT(6), .ADDR_WIDTH(AW), .RD_LATENCY(2)) u_dut_b (
    .clk_in(clk), .rst_n_in(rst_n), .sweep_start_in(b_start),
    .sweep_busy_out(b_busy), .sweep_done_out(b_done), .obj_valid_out(b_ov),
    .obj_base_addr_out(b_base), .obj_lane_mask_out(b_mask), .obj_data_out(b_data),
    .phys_wr_valid_in(b_pv), .phys_wr_ready_out(b_prdy), .phys_wr_addr_in(b_pa), .phys_wr_obj_in(b_po),
    .ar_wr_valid_in(b_av), .ar_wr_ready_out(b_ardy), .ar_wr_addr_in(b_aa), .ar_wr_obj_in(b_ao),
    .st_read_valid_out(b_rv), .st_read_addrs_out(b_ra), .st_read_objects_in(b_d2),
    .st_read_valid_in(b_v2), .st_write_valid_out(b_wv), .st_write_addr_out(b_wa),
    .st_write_object_out(b_wo)
  );

  // Storage model: 2-cycle read latency, read-first, pipeline deliberately not reset.
  always @(posedge clk) begin
    a_v1 <= a_rv;
    a_v2 <= a_v1;
    b_v1 <= b_rv;
    b_v2 <= b_v1;
    for (int i = 0; i < 4; i++) begin
      a_d1[i] <= mem[a_ra[i]];
      a_d2[i] <= a_d1[i];
      b_d1[i] <= mem[b_ra[i]];
      b_d2[i] <= b_d1[i];
    end
    if (mem_init) begin
      for (int k = 0; k < 256; k++) mem[k] <= obj_pat(k);
    end else if (b_wv) begin
      mem[b_wa] <= b_wo;
    end
  end

  int b_beats = 0;
  int b_dones = 0;
  always @(negedge clk) begin
    if (b_ov === 1'b1) b_beats <= b_beats + 1;
    if (b_done === 1'b1) b_dones <= b_dones + 1;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int bb, bd, grant_k, exp_grant;

  initial begin
    rst_n = 1'b0; mem_init = 1'b1;
    a_start = 1'b0; b_start = 1'b0;
    b_pv = 1'b1; b_av = 1'b0; b_pa = '0; b_aa = '0; b_po = '0; b_ao = '0;
    repeat (3) cyc();
    mem_init = 1'b0;
    @(negedge clk);
    chk("rst_busy",  128'(b_busy), 128'(0));
    chk("rst_done",  128'(b_done), 128'(0));
    chk("rst_ov",    128'(b_ov),   128'(0));
    chk("rst_rv",    128'(b_rv),   128'(0));
    chk("rst_wv",    128'(b_wv),   128'(0));
    chk("rst_prdy",  128'(b_prdy), 128'(0));
    cyc();
    b_pv = 1'b0;
    rst_n = 1'b1;
    cyc();

    // arbitration: both requesting for 4 cycles
    b_pv = 1'b1; b_pa = 8'd10; b_po = obj_pat(100);
    b_av = 1'b1; b_aa = 8'd20; b_ao = obj_pat(200);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("arb_prdy", 128'(b_prdy), 128'(k % 2 == 0));
      chk("arb_ardy", 128'(b_ardy), 128'(k % 2 == 1));
      if (k > 0) begin
        chk("arb_wv", 128'(b_wv), 128'(1));
        chk("arb_wa", 128'(b_wa), (k % 2 == 1) ? 128'(10) : 128'(20));
      end
      cyc();
    end
    b_pv = 1'b0; b_av = 1'b0;
    @(negedge clk);
    chk("arb_wv_last", 128'(b_wv), 128'(1));
    chk("arb_wa_last", 128'(b_wa), 128'(20));
    chk("arb_wo_last", 128'(b_wo), 128'(obj_pat(200)));
    cyc();
    b_av = 1'b1;
    @(negedge clk);
    chk("arb_single_ar", 128'(b_ardy), 128'(1));
    chk("arb_single_p",  128'(b_prdy), 128'(0));
    cyc();
    b_av = 1'b0;
    @(negedge clk);
    chk("arb_single_wa", 128'(b_wa), 128'(20));
    cyc();
    @(negedge clk);
    chk("arb_pulse_end", 128'(b_wv), 128'(0));
    cyc();

    // OBJ_COUNT=4 sweep
    a_start = 1'b1;
    @(negedge clk);
    chk("a_busy_pre", 128'(a_busy), 128'(0));
    cyc();
    a_start = 1'b0;
    @(negedge clk);
    chk("a_rv",    128'(a_rv), 128'(1));
    chk("a_addrs", 128'({a_ra[3], a_ra[2], a_ra[1], a_ra[0]}), 128'(32'h03020100));
    chk("a_busy",  128'(a_busy), 128'(1));
    cyc(); @(negedge clk);
    chk("a_rv_off", 128'(a_rv), 128'(0));
    cyc(); @(negedge clk);
    chk("a_ov_early", 128'(a_ov), 128'(0));
    cyc(); @(negedge clk);
    chk("a_ov",    128'(a_ov),    128'(1));
    chk("a_mask",  128'(a_mask),  128'(4'b1111));
    chk("a_base",  128'(a_base),  128'(0));
    chk("a_done",  128'(a_done),  128'(1));
    chk("a_data0", 128'(a_data[0]), 128'(obj_pat(0)));
    chk("a_data3", 128'(a_data[3]), 128'(obj_pat(3)));
    cyc(); @(negedge clk);
    chk("a_busy_end", 128'(a_busy), 128'(0));
    chk("a_done_end", 128'(a_done), 128'(0));
    cyc();

    // OBJ_COUNT=6 sweep
    b_start = 1'b1;
    cyc();
    b_start = 1'b0;
    @(negedge clk);
    chk("b_rv0",    128'(b_rv), 128'(1));
    chk("b_addrs0", 128'({b_ra[3], b_ra[2], b_ra[1], b_ra[0]}), 128'(32'h03020100));
    cyc(); @(negedge clk);
    chk("b_rv1",    128'(b_rv), 128'(1));
    chk("b_addrs1", 128'({b_ra[3], b_ra[2], b_ra[1], b_ra[0]}), 128'(32'h00000504));
    cyc(); @(negedge clk);
    chk("b_rv_off", 128'(b_rv), 128'(0));
    cyc(); @(negedge clk);
    chk("b_ov0",   128'(b_ov),   128'(1));
    chk("b_base0", 128'(b_base), 128'(0));
    chk("b_mask0", 128'(b_mask), 128'(4'b1111));
    chk("b_done0", 128'(b_done), 128'(0));
    chk("b_data2", 128'(b_data[2]), 128'(obj_pat(2)));
    cyc(); @(negedge clk);
    chk("b_ov1",   128'(b_ov),   128'(1));
    chk("b_base1", 128'(b_base), 128'(4));
    chk("b_mask1", 128'(b_mask), 128'(4'b0011));
    chk("b_done1", 128'(b_done), 128'(1));
    chk("b_data5", 128'(b_data[1]), 128'(obj_pat(5)));
    chk("b_busy1", 128'(b_busy), 128'(1));
    cyc(); @(negedge clk);
    chk("b_busy_end", 128'(b_busy), 128'(0));
    chk("b_ov_end",   128'(b_ov),   128'(0));
    cyc();

    // start held high while busy
    bb = b_beats; bd = b_dones;
    b_start = 1'b1;
    repeat (5) cyc();
    b_start = 1'b0;
    repeat (10) cyc();
    chk("busy_start_beats", 128'(b_beats - bb), 128'(2));
    chk("busy_start_dones", 128'(b_dones - bd), 128'(1));

    // write during a sweep
`ifdef SWEEP_WRITE_LOCK_EN
    exp_grant = 6;
`else
    exp_grant = 2;
`endif
    grant_k = -1;
    b_start = 1'b1;
    cyc();
    b_start = 1'b0;
    cyc();
    b_pv = 1'b1; b_pa = 8'd30; b_po = obj_pat(300);
    for (int k = 2; k < 16; k++) begin
      @(negedge clk);
      if (b_prdy) begin
        grant_k = k;
        cyc();
        b_pv = 1'b0;
        @(negedge clk);
        chk("lock_wv", 128'(b_wv), 128'(1));
        chk("lock_wa", 128'(b_wa), 128'(30));
        break;
      end
      cyc();
    end
    b_pv = 1'b0;
    chk("lock_grant_cycle", 128'(grant_k), 128'(exp_grant));
    repeat (8) cyc();

    // async reset in the middle of DRAIN
    b_start = 1'b1;
    cyc();
    b_start = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b0;
    b_pv = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 128'(b_busy), 128'(0));
    chk("mid_rst_rv",   128'(b_rv),   128'(0));
    chk("mid_rst_ov",   128'(b_ov),   128'(0));
    chk("mid_rst_done", 128'(b_done), 128'(0));
    chk("mid_rst_prdy", 128'(b_prdy), 128'(0));
    chk("mid_rst_wv",   128'(b_wv),   128'(0));
    cyc();
    b_pv = 1'b0;
    rst_n = 1'b1;
    bb = b_beats; bd = b_dones;
    repeat (8) cyc();
    chk("post_rst_beats", 128'(b_beats - bb), 128'(0));
    chk("post_rst_dones", 128'(b_dones - bd), 128'(0));
    bb = b_beats; bd = b_dones;
    b_start = 1'b1;
    cyc();
    b_start = 1'b0;
    repeat (10) cyc();
    chk("clean_beats", 128'(b_beats - bb), 128'(2));
    chk("clean_dones", 128'(b_dones - bd), 128'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
